trace_capture: RTL and testbench

Synthesizable on-chip instruction-trace recorder for the tetris350 processor. Each retired cycle it snoops the same per-cycle fields the simulation bench prints: PC, decoded opcode, ALU result, memory address and register write data. It holds them in a circular buffer around a PC-match trigger, then hands the records out one at a time over a valid/ready read port. It sits beside `processor` inside `skeleton`, and its read port drives a debug consumer such as a UART or VGA overlay.

---
 rtl/trace_pkg.sv | 26 ++
 rtl/trace_capture_ram.sv | 23 ++
 rtl/trace_capture.sv | 99 +++++++++
 tb/tb_trace_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the instruction-trace recorder.
// Field offsets assume the default 12-bit PC and 32-bit data widths.
package trace_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    DONE    = 3'd3
  } state_t;

  localparam int OPCODE_W = 5;

  localparam int DEF_PC_W     = 12;
  localparam int DEF_DATA_W   = 32;
  localparam int WDATA_LSB    = 0;
  localparam int MEM_ADDR_LSB = DEF_DATA_W;
  localparam int ALU_LSB      = DEF_DATA_W + DEF_PC_W;
  localparam int OPCODE_LSB   = 2 * DEF_DATA_W + DEF_PC_W;
  localparam int PC_LSB       = OPCODE_LSB + OPCODE_W;

  function automatic int rec_width(input int pc_w, input int data_w);
    return 2 * pc_w + OPCODE_W + 2 * data_w;
  endfunction

endpackage

// File: rtl/trace_capture_ram.sv
// Trace record storage: register array, synchronous write, asynchronous read.
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 93,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture.sv
// Circular trace buffer around a PC-match trigger, drained oldest-first.
// Read port: a record transfers on every rising edge where rd_valid && rd_ready.
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int PC_W   = 12,
  parameter int DATA_W = 32,
  localparam int REC_W = 2 * PC_W + OPCODE_W + 2 * DATA_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic [PC_W-1:0]     trig_pc,
  input  logic [AW-1:0]       post_len,
  input  logic                trace_valid,
  input  logic [PC_W-1:0]     pc,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic [PC_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                rd_ready,
  output logic                rd_valid,
  output logic [REC_W-1:0]    rd_data,
  output logic [2:0]          state,
  output logic [AW:0]         entries
);

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr, rd_ptr, post_cnt;
  logic [AW:0]      entries_q;
  logic             wr_en, hit, rd_fire, last_post;
  logic [REC_W-1:0] wr_rec, ram_rdata;

  assign wr_rec    = {pc, opcode, alu_out, mem_addr, wdata};
  // The oldest record sits 'entries' slots behind the write pointer.
  assign rd_ptr    = wr_ptr - entries_q[AW-1:0];
  assign wr_en     = !arm && trace_valid && (state_q == ARMED || state_q == CAPTURE);
  assign hit       = (state_q == ARMED) && trace_valid && (pc == trig_pc);
  assign last_post = (post_cnt + AW'(1)) == post_len;
  assign rd_valid  = (state_q == DONE) && (entries_q != '0);
  assign rd_fire   = rd_valid && rd_ready;
  assign rd_data   = (state_q == DONE) ? ram_rdata : '0;
  assign state     = state_q;
  assign entries   = entries_q;

  trace_ram #(.DEPTH(DEPTH), .W(REC_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_rec),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ARMED:   if (hit) state_d = (post_len == '0) ? DONE : CAPTURE;
        CAPTURE: if (trace_valid && last_post) state_d = DONE;
        DONE:    if (entries_q == '0 || (rd_fire && entries_q == (AW+1)'(1))) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      post_cnt  <= '0;
      entries_q <= '0;
    end else if (arm) begin
      post_cnt  <= '0;
      entries_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        // Saturate at DEPTH; the write pointer then overwrites the oldest slot.
        if (entries_q != (AW+1)'(DEPTH)) entries_q <= entries_q + (AW+1)'(1);
      end
      if (rd_fire) entries_q <= entries_q - (AW+1)'(1);
      if (hit)
        post_cnt <= '0;
      else if (state_q == CAPTURE && trace_valid)
        post_cnt <= post_cnt + AW'(1);
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: vector table for stalled capture, scoreboard-checked readout.
module tb_trace_capture;

  localparam int DEPTH = 64;
  localparam int PC_W  = 12;
  localparam int DW    = 32;
  localparam int REC_W = 2 * PC_W + 5 + 2 * DW;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             arm = 1'b0;
  logic [PC_W-1:0]  trig_pc = '0;
  logic [5:0]       post_len = '0;
  logic             trace_valid = 1'b0;
  logic [PC_W-1:0]  pc = '0;
  logic [4:0]       opcode = '0;
  logic [DW-1:0]    alu_out = '0;
  logic [PC_W-1:0]  mem_addr = '0;
  logic [DW-1:0]    wdata = '0;
  logic             rd_ready = 1'b0;
  logic             rd_valid;
  logic [REC_W-1:0] rd_data;
  logic [2:0]       state;
  logic [6:0]       entries;

  logic [REC_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit              tv;
    logic [PC_W-1:0] pc;
    bit              cap;
    bit              rdy;
    logic [2:0]      st;
    logic [6:0]      ent;
  } vec_t;

  vec_t vec[13];

  trace_capture #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_pc(trig_pc), .post_len(post_len),
    .trace_valid(trace_valid), .pc(pc), .opcode(opcode), .alu_out(alu_out),
    .mem_addr(mem_addr), .wdata(wdata), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .state(state), .entries(entries)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic feed(input logic [PC_W-1:0] p, input bit tv, input bit push);
    logic [REC_W-1:0] rec;
    trace_valid = tv;
    pc          = p;
    opcode      = 5'($urandom_range(0, 31));
    alu_out     = $urandom();
    mem_addr    = 12'($urandom_range(0, 4095));
    wdata       = $urandom();
    rec = {pc, opcode, alu_out, mem_addr, wdata};
    if (push) exp_q.push_back(rec);
    step();
    trace_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [PC_W-1:0] tp, input logic [5:0] pl);
    trig_pc = tp;
    post_len = pl;
    arm = 1'b1;
    trace_valid = 1'b0;
    step();
    arm = 1'b0;
    chk("arm_state", state, 3'd1);
    chk("arm_entries", entries, 7'd0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bit stop = 0;
    rd_ready = 1'b1;
    while (!stop && (rd_valid || exp_q.size() != 0) && n < budget) begin
      if (exp_q.size() == 0) begin
        chk("extra_record", rd_valid, 1'b0);
        stop = 1;
      end else if (!rd_valid) begin
        chk("stream_valid", rd_valid, 1'b1);
        stop = 1;
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
        step();
        chk("entries_drain", entries, 7'(exp_q.size()));
      end
      n++;
    end
    if (n >= budget) chk("drain_timeout", 32'(n), 32'(budget - 1));
    rd_ready = 1'b0;
    exp_q.delete();
    chk("drain_state", state, 3'd0);
    chk("drain_valid", rd_valid, 1'b0);
  endtask

  initial begin
    // Reset held with arm asserted: reset must win.
    arm = 1'b1;
    step();
    step();
    chk("rst_state", state, 3'd0);
    chk("rst_entries", entries, 7'd0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_data", rd_data, '0);
    arm = 1'b0;
    reset = 1'b0;
    step();
    chk("idle_state", state, 3'd0);

    // Basic trigger: pc 0..8 captured, pc 9 dropped.
    do_arm(12'd5, 6'd3);
    for (int p = 0; p <= 9; p++) begin
      feed(12'(p), 1'b1, p <= 8);
      if (p == 7) chk("basic_capture_state", state, 3'd2);
      if (p == 8) chk("basic_done_state", state, 3'd3);
    end
    chk("basic_entries", entries, 7'd9);
    drain(40);

    // Wrap-around: last 64 records are pc 39..102.
    do_arm(12'd100, 6'd2);
    for (int p = 0; p <= 102; p++) feed(12'(p), 1'b1, p >= 39);
    chk("wrap_state", state, 3'd3);
    chk("wrap_entries", entries, 7'd64);
    drain(100);

    // Stalled capture, table-driven; a matching pc with trace_valid low must not trigger.
    vec[0]  = '{1'b1, 12'd0, 1'b1, 1'b1, 3'd1, 7'd1};
    vec[1]  = '{1'b1, 12'd1, 1'b1, 1'b1, 3'd1, 7'd2};
    vec[2]  = '{1'b0, 12'd3, 1'b0, 1'b1, 3'd1, 7'd2};
    vec[3]  = '{1'b0, 12'd2, 1'b0, 1'b1, 3'd1, 7'd2};
    vec[4]  = '{1'b1, 12'd2, 1'b1, 1'b1, 3'd1, 7'd3};
    vec[5]  = '{1'b1, 12'd3, 1'b1, 1'b1, 3'd2, 7'd4};
    vec[6]  = '{1'b0, 12'd4, 1'b0, 1'b1, 3'd2, 7'd4};
    vec[7]  = '{1'b1, 12'd4, 1'b1, 1'b1, 3'd2, 7'd5};
    vec[8]  = '{1'b0, 12'd5, 1'b0, 1'b1, 3'd2, 7'd5};
    vec[9]  = '{1'b1, 12'd5, 1'b1, 1'b1, 3'd2, 7'd6};
    vec[10] = '{1'b0, 12'd6, 1'b0, 1'b1, 3'd2, 7'd6};
    vec[11] = '{1'b1, 12'd6, 1'b1, 1'b0, 3'd3, 7'd7};
    vec[12] = '{1'b1, 12'd7, 1'b0, 1'b0, 3'd3, 7'd7};
    do_arm(12'd3, 6'd3);
    for (int i = 0; i < 13; i++) begin
      rd_ready = vec[i].rdy;
      feed(vec[i].pc, vec[i].tv, vec[i].cap);
      chk($sformatf("vec%0d_state", i), state, vec[i].st);
      chk($sformatf("vec%0d_entries", i), entries, vec[i].ent);
    end

    // Read backpressure: data held for 5 stalled cycles, then streamed.
    rd_ready = 1'b0;
    begin
      logic [REC_W-1:0] held;
      held = rd_data;
      chk("bp_first", rd_data, exp_q[0]);
      for (int i = 0; i < 5; i++) begin
        step();
        chk("bp_hold_data", rd_data, held);
        chk("bp_hold_valid", rd_valid, 1'b1);
        chk("bp_hold_entries", entries, 7'd7);
      end
    end
    drain(20);

    // post_len = 0: trigger edge goes straight to DONE.
    do_arm(12'd2, 6'd0);
    for (int p = 0; p <= 3; p++) begin
      feed(12'(p), 1'b1, p <= 2);
      if (p == 2) chk("pl0_state", state, 3'd3);
    end
    chk("pl0_entries", entries, 7'd3);
    drain(20);

    // Re-arm during an active read handshake.
    do_arm(12'd1, 6'd2);
    for (int p = 0; p <= 4; p++) feed(12'(p), 1'b1, 1'b0);
    chk("rearm_pre_state", state, 3'd3);
    chk("rearm_pre_entries", entries, 7'd4);
    rd_ready = 1'b1;
    chk("rearm_pre_valid", rd_valid, 1'b1);
    trig_pc = 12'd50;
    post_len = 6'd1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    rd_ready = 1'b0;
    chk("rearm_state", state, 3'd1);
    chk("rearm_entries", entries, 7'd0);
    chk("rearm_valid", rd_valid, 1'b0);
    feed(12'd50, 1'b1, 1'b1);
    feed(12'd51, 1'b1, 1'b1);
    chk("rearm_done_state", state, 3'd3);
    chk("rearm_done_entries", entries, 7'd2);
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
